// File: rtl/uart_pkg.sv
// uart_pkg: register map, status bit positions and FSM state types shared by the UART and its master
package uart_pkg;
  localparam logic [4:0] RX_BASE = 5'd0;
  localparam logic [4:0] TX_BASE = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;
  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;
  localparam int OVR_BIT = 3;
  localparam int FERR_BIT = 2;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronises rxd, samples 8N1 frames mid-bit, emits the byte with one-cycle valid and frame-error pulses
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr
);
  localparam int W = $clog2(DIV + 1);
  rx_state_t state, state_n;
  logic s1, s2, tick;
  logic [W-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  assign tick = cnt == W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= R_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == R_IDLE ? (s2 ? R_IDLE : R_START) :
              !tick ? state :
              state == R_START ? (s2 ? R_IDLE : R_DATA) :
              state == R_DATA ? (idx == 3'd7 ? R_STOP : R_DATA) : R_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s2, s1} <= 2'b11;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      {s2, s1} <= {s1, rxd};
      cnt <= state == R_IDLE ? W'(DIV / 2) : tick ? W'(DIV) : cnt - 1'b1;
      if (state == R_DATA && tick) begin
        sh <= {s2, sh[7:1]};
        idx <= idx + 3'd1;
      end
    end
  always_comb begin
    data = sh;
    valid = state == R_STOP && tick && s2;
    ferr = state == R_STOP && tick && !s2;
  end
endmodule

// File: rtl/uart_avs_rs232.sv
// uart_avs_rs232: Avalon-MM slave 8N1 UART exposing RX, TX and STATUS registers with one wait cycle per access
module uart_avs_rs232
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 115200,
  parameter int DIV = CLK_HZ / BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  localparam int W = $clog2(DIV + 1);
  tx_state_t tx_state, tx_state_n;
  logic [W-1:0] tx_cnt;
  logic [2:0] tx_idx;
  logic [7:0] tx_sh, op_data, rx_data, rx_byte, status;
  logic [4:0] op_addr;
  logic op_rd, op_wr, done, rx_rd, st_rd, tx_start, tx_busy, tx_tick;
  logic rx_full, overrun, frame_err, rx_valid, rx_ferr;
  logic unused;
  assign unused = &{1'b0, avs_writedata[31:8]};
  uart_rx_core #(.DIV(DIV)) u_rx (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (uart_rxd),
    .data (rx_byte),
    .valid(rx_valid),
    .ferr (rx_ferr)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      avs_waitrequest <= 1'b1;
      op_rd <= 1'b0;
      op_wr <= 1'b0;
      op_addr <= '0;
      op_data <= '0;
    end else begin
      avs_waitrequest <= !((avs_read || avs_write) && avs_waitrequest);
      if (avs_waitrequest) begin
        op_rd <= avs_read;
        op_wr <= avs_write && !avs_read;
        op_addr <= avs_address;
        op_data <= avs_writedata[7:0];
      end
    end
  assign done = !avs_waitrequest;
  assign rx_rd = done && op_rd && op_addr == RX_BASE;
  assign st_rd = done && op_rd && op_addr == STATUS_BASE;
  assign tx_start = done && op_wr && op_addr == TX_BASE && !tx_busy;
  always_comb begin
    status = '0;
    status[RX_OK_BIT] = rx_full;
    status[TX_OK_BIT] = !tx_busy;
    status[OVR_BIT] = overrun;
    status[FERR_BIT] = frame_err;
    avs_readdata = !(done && op_rd) ? '0 :
                   op_addr == RX_BASE ? {24'b0, rx_data} :
                   op_addr == STATUS_BASE ? {24'b0, status} : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_data <= '0;
      rx_full <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_valid && (!rx_full || rx_rd)) rx_data <= rx_byte;
      rx_full <= rx_valid || (rx_full && !rx_rd);
      overrun <= (rx_valid && rx_full && !rx_rd) || (overrun && !st_rd);
      frame_err <= rx_ferr || (frame_err && !st_rd);
    end
  assign tx_busy = tx_state != T_IDLE;
  assign tx_tick = tx_cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tx_state <= T_IDLE;
    else tx_state <= tx_state_n;
  always_comb
    tx_state_n = tx_state == T_IDLE ? (tx_start ? T_START : T_IDLE) :
                 !tx_tick ? tx_state :
                 tx_state == T_START ? T_DATA :
                 tx_state == T_DATA ? (tx_idx == 3'd7 ? T_STOP : T_DATA) : T_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh <= '0;
    end else begin
      tx_cnt <= tx_state == T_IDLE || tx_tick ? W'(DIV - 1) : tx_cnt - 1'b1;
      if (tx_start) tx_sh <= op_data;
      else if (tx_state == T_DATA && tx_tick) begin
        tx_sh <= tx_sh >> 1;
        tx_idx <= tx_idx + 3'd1;
      end
    end
  always_comb
    uart_txd = tx_state == T_START ? 1'b0 : tx_state == T_DATA ? tx_sh[0] : 1'b1;
endmodule
